// File: rtl/prim_assembler_if.sv
// Vertex/color FIFO read side plus primitive output side of the primitive assembler.
// slave = assembler, master = surrounding FIFOs and consumer.
interface prim_assembler_if #(
   parameter int DATA_W = 96,
   parameter int VERTS  = 3
);
   logic                    vertex_empty;
   logic                    color_empty;
   logic [DATA_W-1:0]       vertex_in;
   logic [DATA_W-1:0]       color_in;
   logic                    strip_mode;
   logic                    dequeue;
   logic                    vertex_rd_en;
   logic                    color_rd_en;
   logic                    ready;
   logic                    flush;
   logic [VERTS*DATA_W-1:0] vertex_out;
   logic [VERTS*DATA_W-1:0] color_out;
   logic [15:0]             prim_count;

   modport master (
      output vertex_empty, color_empty, vertex_in, color_in, strip_mode, dequeue,
      input  vertex_rd_en, color_rd_en, ready, flush, vertex_out, color_out, prim_count
   );

   modport slave (
      input  vertex_empty, color_empty, vertex_in, color_in, strip_mode, dequeue,
      output vertex_rd_en, color_rd_en, ready, flush, vertex_out, color_out, prim_count
   );
endinterface

// File: rtl/prim_assembler.sv
// Gathers VERTS vertex/color pairs from two lock-stepped FIFOs into primitives (list or strip),
// with a flush marker that discards the partial primitive and a one-deep output buffer.
module prim_assembler #(
   parameter int               DATA_W     = 96,
   parameter int               VERTS      = 3,
   parameter logic [DATA_W-1:0] FLUSH_WORD = '1
) (
   input logic             clk,
   input logic             reset,
   prim_assembler_if.slave bus
);
   localparam int CNT_W = $clog2(VERTS + 1);

   typedef enum logic {FILL, FULL} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, g_cnt;
   logic                    rd_q, en_q, strip_q, strip_d, flush_q, ready_q, ready_d;
   logic [15:0]             prim_q;
   logic [DATA_W-1:0]       sv_q [VERTS];
   logic [DATA_W-1:0]       sc_q [VERTS];
   logic [DATA_W-1:0]       sv_d [VERTS];
   logic [DATA_W-1:0]       sc_d [VERTS];
   logic [DATA_W-1:0]       gv   [VERTS];
   logic [DATA_W-1:0]       gc   [VERTS];
   logic [VERTS*DATA_W-1:0] vout_q, cout_q, vout_d, cout_d;
   logic                    marker, wr, xfer, pop;

   // Arriving data is merged into the gather view first, so a primitive completed this cycle
   // can move to the output buffer at once; this is what sustains one strip primitive per cycle.
   always_comb begin
      marker = rd_q && (bus.vertex_in == FLUSH_WORD) && (bus.color_in == FLUSH_WORD);
      wr     = rd_q && !marker;
      gv     = sv_q;
      gc     = sc_q;
      for (int i = 0; i < VERTS; i++) begin
         if (wr && int'(cnt_q) == i) begin
            gv[i] = bus.vertex_in;
            gc[i] = bus.color_in;
         end
      end
      g_cnt  = cnt_q + CNT_W'(wr);
      xfer   = (g_cnt == CNT_W'(VERTS)) && (!ready_q || bus.dequeue);

      vout_d = vout_q;
      cout_d = cout_q;
      sv_d   = gv;
      sc_d   = gc;
      cnt_d  = g_cnt;
      if (xfer) begin
         for (int i = 0; i < VERTS; i++) begin
            vout_d[i*DATA_W +: DATA_W] = gv[i];
            cout_d[i*DATA_W +: DATA_W] = gc[i];
         end
      end
      if (marker) begin
         cnt_d = '0;
      end else if (xfer) begin
         if (strip_q) begin
            for (int i = 0; i < VERTS - 1; i++) begin
               sv_d[i] = gv[i+1];
               sc_d[i] = gc[i+1];
            end
            cnt_d = CNT_W'(VERTS - 1);
         end else begin
            cnt_d = '0;
         end
      end

      ready_d = xfer ? 1'b1 : (bus.dequeue ? 1'b0 : ready_q);
      // Mode is only picked up between primitives, never with a read outstanding.
      strip_d = (cnt_q == '0 && !rd_q) ? bus.strip_mode : strip_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (cnt_d == CNT_W'(VERTS)) state_d = FULL;
         FULL:    if (xfer)                   state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // A pop is issued only if its data is guaranteed a free slot on return.
   always_comb begin
      pop = en_q && !bus.vertex_empty && !bus.color_empty && !flush_q && (state_d == FILL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         en_q    <= 1'b0;
         strip_q <= 1'b0;
         flush_q <= 1'b0;
         ready_q <= 1'b0;
         prim_q  <= '0;
         vout_q  <= '0;
         cout_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         rd_q    <= pop;
         en_q    <= 1'b1;
         strip_q <= strip_d;
         flush_q <= marker;
         ready_q <= ready_d;
         prim_q  <= prim_q + 16'(xfer);
         vout_q  <= vout_d;
         cout_q  <= cout_d;
      end
   end

   always_ff @(posedge clk) begin
      sv_q <= sv_d;
      sc_q <= sc_d;
   end

   assign bus.vertex_rd_en = pop;
   assign bus.color_rd_en  = pop;
   assign bus.ready        = ready_q;
   assign bus.flush        = flush_q;
   assign bus.vertex_out   = vout_q;
   assign bus.color_out    = cout_q;
   assign bus.prim_count   = prim_q;
endmodule

// File: tb/tb_prim_assembler.sv
// Scoreboard bench for prim_assembler: FIFO model feeds the DUT, expected primitives are queued
// as stimulus is pushed and popped whenever prim_count advances.
module tb_prim_assembler;
   localparam int DATA_W = 96;
   localparam int VERTS  = 3;
   localparam int W      = VERTS * DATA_W;
   localparam logic [DATA_W-1:0] FW = '1;

   logic clk;
   logic reset;
   int   tests_run, tests_failed;
   int   cyc, pops, flush_cnt, n_exp;
   logic pop_pend;
   logic [15:0] last_pc;
   logic [DATA_W-1:0] vq[$], cq[$];
   logic [W-1:0] ev_q[$], ec_q[$];
   int   prim_cyc[$];

   prim_assembler_if #(.DATA_W(DATA_W), .VERTS(VERTS)) bus ();

   prim_assembler #(.DATA_W(DATA_W), .VERTS(VERTS), .FLUSH_WORD(FW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] vv(input int k);
      return {32'(k), 32'h5EED_0000, 32'(k * 7 + 1)};
   endfunction

   function automatic logic [DATA_W-1:0] cc(input int k);
      return {32'hC0C0_0000 | 32'(k), 32'(k * 3), 32'h0BAD_F00D};
   endfunction

   task automatic push_raw(input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] c);
      vq.push_back(v);
      cq.push_back(c);
      bus.vertex_empty = 1'b0;
      bus.color_empty  = 1'b0;
   endtask

   task automatic push_n(input int first, input int last);
      for (int k = first; k <= last; k++) push_raw(vv(k), cc(k));
   endtask

   task automatic expect_raw(input logic [W-1:0] v, input logic [W-1:0] c);
      ev_q.push_back(v);
      ec_q.push_back(c);
      n_exp++;
   endtask

   task automatic expect3(input int a, input int b, input int c);
      expect_raw({vv(c), vv(b), vv(a)}, {cc(c), cc(b), cc(a)});
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((ev_q.size() != 0 || vq.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk({tag, "_drain"}, W'(ev_q.size()), W'(0));
   endtask

   // FIFO model: pop request sampled mid-low-phase, data presented just after the popping edge.
   always @(negedge clk) begin
      #2;
      pop_pend = reset && bus.vertex_rd_en;
      chk("rd_pair", W'(bus.color_rd_en), W'(bus.vertex_rd_en));
   end

   always @(posedge clk) begin
      cyc++;
      #1;
      if (pop_pend) begin
         if (vq.size() == 0) begin
            chk("fifo_underflow", W'(1), W'(0));
         end else begin
            bus.vertex_in = vq.pop_front();
            bus.color_in  = cq.pop_front();
            pops++;
         end
         pop_pend = 1'b0;
      end
      bus.vertex_empty = (vq.size() == 0);
      bus.color_empty  = (cq.size() == 0);
   end

   always @(negedge clk) begin
      #3;
      if (!reset) begin
         last_pc = '0;
      end else if (bus.prim_count != last_pc) begin
         chk("prim_step", W'(bus.prim_count), W'(last_pc + 16'd1));
         chk("prim_ready", W'(bus.ready), W'(1));
         prim_cyc.push_back(cyc);
         if (ev_q.size() == 0) begin
            chk("prim_unexpected", W'(1), W'(0));
         end else begin
            chk("prim_vtx", bus.vertex_out, ev_q.pop_front());
            chk("prim_col", bus.color_out, ec_q.pop_front());
         end
         last_pc = bus.prim_count;
      end
      if (reset && bus.flush) flush_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fb, pb, gap, n;
      tests_run = 0; tests_failed = 0; cyc = 0; pops = 0; flush_cnt = 0; n_exp = 0;
      pop_pend = 1'b0; last_pc = '0;
      reset = 1'b0;
      bus.vertex_empty = 1'b1; bus.color_empty = 1'b1;
      bus.vertex_in = '0; bus.color_in = '0;
      bus.strip_mode = 1'b0; bus.dequeue = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", W'(bus.ready), W'(0));
      chk("rst_flush", W'(bus.flush), W'(0));
      chk("rst_count", W'(bus.prim_count), W'(0));
      chk("rst_vout", bus.vertex_out, W'(0));
      chk("rst_rd", W'(bus.vertex_rd_en), W'(0));
      reset = 1'b1;

      // single list primitive held without dequeue
      @(negedge clk);
      push_n(1, 3);
      expect3(1, 2, 3);
      drain("a", 40);
      repeat (10) @(negedge clk);
      chk("a_hold_vtx", bus.vertex_out, {vv(3), vv(2), vv(1)});
      chk("a_hold_col", bus.color_out, {cc(3), cc(2), cc(1)});
      chk("a_hold_ready", W'(bus.ready), W'(1));
      chk("a_count", W'(bus.prim_count), W'(1));
      bus.dequeue = 1'b1;
      @(negedge clk);
      bus.dequeue = 1'b0;
      chk("a_deq_ready", W'(bus.ready), W'(0));
      @(negedge clk);

      // flush marker discards a partial primitive
      bus.dequeue = 1'b1;
      fb = flush_cnt;
      push_n(11, 12);
      push_raw(FW, FW);
      push_n(14, 16);
      expect3(14, 15, 16);
      drain("b", 60);
      chk("b_flush", W'(flush_cnt - fb), W'(1));

      // marker on vertex only is plain data
      fb = flush_cnt;
      push_raw(FW, '0);
      push_n(22, 23);
      expect_raw({vv(23), vv(22), FW}, {cc(23), cc(22), {DATA_W{1'b0}}});
      drain("c", 60);
      chk("c_flush", W'(flush_cnt - fb), W'(0));

      // list throughput
      prim_cyc.delete();
      push_n(41, 46);
      expect3(41, 42, 43);
      expect3(44, 45, 46);
      drain("d", 60);
      n = prim_cyc.size();
      chk("d_nprims", W'(n), W'(2));
      gap = (n >= 2) ? prim_cyc[n-1] - prim_cyc[0] : -1;
      chk("d_gap", W'(gap), W'(3));

      // strip mode, one primitive per cycle
      bus.strip_mode = 1'b1;
      repeat (3) @(negedge clk);
      prim_cyc.delete();
      push_n(51, 55);
      expect3(51, 52, 53);
      expect3(52, 53, 54);
      expect3(53, 54, 55);
      drain("e", 60);
      n = prim_cyc.size();
      chk("e_nprims", W'(n), W'(3));
      gap = (n >= 3) ? prim_cyc[n-1] - prim_cyc[0] : -1;
      chk("e_gap", W'(gap), W'(2));
      chk("e_count", W'(bus.prim_count), W'(n_exp));
      fb = flush_cnt;
      push_raw(FW, FW);
      repeat (4) @(negedge clk);
      bus.strip_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("e_flush", W'(flush_cnt - fb), W'(1));

      // backpressure: output and gather fill, then release
      bus.dequeue = 1'b0;
      pb = pops;
      push_n(61, 69);
      expect3(61, 62, 63);
      expect3(64, 65, 66);
      expect3(67, 68, 69);
      repeat (30) @(negedge clk);
      chk("f_pops", W'(pops - pb), W'(6));
      chk("f_left", W'(vq.size()), W'(3));
      chk("f_ready", W'(bus.ready), W'(1));
      bus.dequeue = 1'b1;
      drain("f", 80);
      chk("f_count", W'(bus.prim_count), W'(n_exp));

      // reset mid-gather
      pb = pops;
      push_n(71, 72);
      n = 0;
      while (pops - pb < 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("g_pre_pops", W'(pops - pb), W'(2));
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("g_rst_ready", W'(bus.ready), W'(0));
      chk("g_rst_flush", W'(bus.flush), W'(0));
      chk("g_rst_count", W'(bus.prim_count), W'(0));
      chk("g_rst_vout", bus.vertex_out, W'(0));
      chk("g_rst_cout", bus.color_out, W'(0));
      chk("g_rst_rd", W'(bus.vertex_rd_en), W'(0));
      n_exp = 0;
      push_n(73, 75);
      expect3(73, 74, 75);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #2;
      chk("g_first_pop", W'(bus.vertex_rd_en), W'(0));
      drain("g", 60);
      chk("g_count", W'(bus.prim_count), W'(n_exp));

      repeat (5) @(negedge clk);
      chk("end_scoreboard", W'(ev_q.size()), W'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
